// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one registered bitwise gate unit among N_REQ requesters.
// Optional `GATE_OP_ARB_PERF_EN adds saturating busy_cnt/stall_cnt outputs.
module gate_op_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [3*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err
`ifdef GATE_OP_ARB_PERF_EN
  ,
  output logic [15:0]            busy_cnt,
  output logic [15:0]            stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   ptr;
  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   scan_idx [N_REQ];
  logic [2:0]        op_arr   [N_REQ];
  logic [WIDTH-1:0]  a_arr    [N_REQ];
  logic [WIDTH-1:0]  b_arr    [N_REQ];
  logic [2:0]        op_p0;
  logic [WIDTH-1:0]  a_p0, b_p0;

  function automatic logic [WIDTH:0] gate_eval(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    gate_eval = {1'b0, a & b};
      3'd1:    gate_eval = {1'b0, a | b};
      3'd2:    gate_eval = {1'b0, a ^ b};
      3'd3:    gate_eval = {1'b0, ~(a ^ b)};
      3'd4:    gate_eval = {1'b0, ~(a | b)};
      3'd5:    gate_eval = {1'b0, ~(a & b)};
      3'd6:    gate_eval = {1'b0, ~a};
      default: gate_eval = {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[3*g +: 3];
    assign a_arr[g]  = req_a[WIDTH*g +: WIDTH];
    assign b_arr[g]  = req_b[WIDTH*g +: WIDTH];
  end

  // Search order starts at ptr and wraps; lowest scan position wins.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx[k] = ID_W'((int'(ptr) + k) % N_REQ);
    end
  end

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[scan_idx[k]]) begin
        grant_any = 1'b1;
        grant_id  = scan_idx[k];
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          req_ready[grant_id] = rst_n;
          state_next          = EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_any) rsp_id <= grant_id;
      if (state == EXEC) {rsp_err, rsp_data} <= gate_eval(op_p0, a_p0, b_p0);
      if (state == RESP && rsp_ready) ptr <= (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
    end
  end

  // Stage p0: operand capture at request handshake
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_any) begin
      op_p0 <= op_arr[grant_id];
      a_p0  <= a_arr[grant_id];
      b_p0  <= b_arr[grant_id];
    end
  end

`ifdef GATE_OP_ARB_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (state != IDLE) busy_cnt <= sat_inc(busy_cnt);
      if (state == RESP && !rsp_ready) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule
